instr_decode: RTL and testbench

Decode/issue stage that turns 32-bit instruction words into the 5-bit ALU opcode, operand selects and control bits consumed by the execute stage and the `alu` datapath. It sits between fetch and execute, with valid/ready handshakes on both sides. It holds one registered output slot and keeps a register scoreboard that stalls issue on RAW/WAW hazards until writeback clears them. It also owns the HALT state.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/instr_decode_scoreboard.sv | 44 ++++
 rtl/instr_decode.sv | 163 ++++++++++++++++
 tb/tb_instr_decode.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode types: opcode map, instruction field positions, decoded bundle.
package cpu_pkg;

    localparam int CPU_XLEN = 32;
    localparam int CPU_RW   = 5;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int IFLAG  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;
    localparam int IMM_W  = 16;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b00010,
        OP_SUBB = 5'b00011,
        OP_LSR  = 5'b00100,
        OP_ASR  = 5'b00101,
        OP_SL   = 5'b00110,
        OP_AND  = 5'b00111,
        OP_OR   = 5'b01000,
        OP_NOT  = 5'b01001,
        OP_LD   = 5'b01010,
        OP_ST   = 5'b01011,
        OP_MOV  = 5'b01100,
        OP_POP  = 5'b10000,
        OP_PUSH = 5'b10001,
        OP_HALT = 5'b11111
    } opcode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic [4:0]          alu_op;
        logic [CPU_RW-1:0]   rd;
        logic [CPU_RW-1:0]   rs1;
        logic [CPU_RW-1:0]   rs2;
        logic                src_b_imm;
        logic [CPU_XLEN-1:0] imm;
        logic                reg_we;
        logic                mem_rd;
        logic                mem_wr;
        logic                sp_inc;
        logic                sp_dec;
        logic                halt;
        logic                illegal;
    } bundle_t;

endpackage

// File: rtl/instr_decode_scoreboard.sv
// Register busy vector: set on issue, cleared by writeback or by a flushed bundle.
module scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [RW-1:0] set_rd,
    input  logic          clr_en,
    input  logic [RW-1:0] clr_rd,
    input  logic          kill_en,
    input  logic [RW-1:0] kill_rd,
    input  logic [RW-1:0] rs1,
    input  logic [RW-1:0] rs2,
    input  logic [RW-1:0] rd,
    input  logic          chk_rs2,
    input  logic          chk_rd,
    output logic          hazard
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Clears applied first so a same-cycle set on the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)  busy_nxt[clr_rd]  = 1'b0;
        if (kill_en) busy_nxt[kill_rd] = 1'b0;
        if (set_en)  busy_nxt[set_rd]  = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // Registered busy only: a writeback this cycle does not release a waiter until next cycle.
    assign hazard = busy[rs1] | (chk_rs2 & busy[rs2]) | (chk_rd & busy[rd]);

endmodule

// File: rtl/instr_decode.sv
// Decode/issue stage: one registered output slot, RAW/WAW scoreboard stall, HALT state.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [XLEN-1:0]         in_instr,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              alu_op,
    output logic [$clog2(NREG)-1:0] rd,
    output logic [$clog2(NREG)-1:0] rs1,
    output logic [$clog2(NREG)-1:0] rs2,
    output logic                    src_b_imm,
    output logic [XLEN-1:0]         imm,
    output logic                    reg_we,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic                    sp_inc,
    output logic                    sp_dec,
    output logic                    halt,
    output logic                    illegal,
    input  logic                    wb_valid,
    input  logic [$clog2(NREG)-1:0] wb_rd,
    input  logic                    flush
);

    localparam int RW = $clog2(NREG);

    function automatic bundle_t decode_instr(input logic [CPU_XLEN-1:0] instr);
        bundle_t    b;
        logic [4:0] opc;
        b         = '0;
        opc       = instr[OPC_HI:OPC_LO];
        b.rd      = instr[RD_HI:RD_LO];
        b.rs1     = instr[RS1_HI:RS1_LO];
        b.rs2     = instr[RS2_HI:RS2_LO];
        b.alu_op  = opc;
        b.src_b_imm = instr[IFLAG];
        b.imm     = {{(CPU_XLEN-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
        case (opc)
            OP_ADD, OP_SUB, OP_SUBB, OP_LSR, OP_ASR, OP_SL, OP_NOT: b.reg_we = 1'b1;
            OP_AND, OP_OR: begin
                b.reg_we = 1'b1;
                b.imm    = {{(CPU_XLEN-IMM_W){1'b0}}, instr[IMM_W-1:0]};
            end
            OP_MOV: begin
                b.reg_we    = 1'b1;
                b.src_b_imm = 1'b1;
            end
            OP_LD: begin
                b.alu_op    = OP_ADD;
                b.src_b_imm = 1'b1;
                b.reg_we    = 1'b1;
                b.mem_rd    = 1'b1;
            end
            OP_ST: begin
                b.alu_op    = OP_ADD;
                b.src_b_imm = 1'b1;
                b.mem_wr    = 1'b1;
            end
            OP_PUSH: begin
                b.alu_op = OP_ADD;
                b.mem_wr = 1'b1;
                b.sp_dec = 1'b1;
            end
            OP_POP: begin
                b.reg_we = 1'b1;
                b.mem_rd = 1'b1;
                b.sp_inc = 1'b1;
            end
            OP_HALT: b.halt = 1'b1;
            default: begin
                // Illegal words still carry their specifiers so hazard checks stay meaningful.
                b.alu_op    = '0;
                b.src_b_imm = 1'b0;
                b.illegal   = 1'b1;
            end
        endcase
        if (b.rd == '0) b.reg_we = 1'b0;
        return b;
    endfunction

    bundle_t      dec;
    bundle_t      out_q;
    logic         out_valid_q;
    logic         hazard;
    logic         accept;
    logic         kill;
    issue_state_e state;
    issue_state_e state_nxt;

    assign dec = decode_instr(in_instr);

    // Killed bundle is the one still sitting in the slot when flush arrives.
    assign kill     = flush & out_valid_q & ~out_ready;
    assign in_ready = rst_n & (state == ST_RUN) & ~flush & ~hazard & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    scoreboard #(.NREG(NREG), .RW(RW)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (accept & dec.reg_we),
        .set_rd  (dec.rd),
        .clr_en  (wb_valid),
        .clr_rd  (wb_rd),
        .kill_en (kill & out_q.reg_we),
        .kill_rd (out_q.rd),
        .rs1     (dec.rs1),
        .rs2     (dec.rs2),
        .rd      (dec.rd),
        .chk_rs2 (~dec.src_b_imm),
        .chk_rd  (dec.reg_we),
        .hazard  (hazard)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (accept && dec.halt) state_nxt = ST_HALTED;
            ST_HALTED: if (flush)              state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
        end else if (out_ready || flush) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_op    = out_q.alu_op;
    assign rd        = out_q.rd;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign src_b_imm = out_q.src_b_imm;
    assign imm       = out_q.imm;
    assign reg_we    = out_q.reg_we;
    assign mem_rd    = out_q.mem_rd;
    assign mem_wr    = out_q.mem_wr;
    assign sp_inc    = out_q.sp_inc;
    assign sp_dec    = out_q.sp_dec;
    assign halt      = out_q.halt;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboarded bench for instr_decode: directed plan cases plus randomized traffic.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic        src_b_imm, reg_we, mem_rd, mem_wr, sp_inc, sp_dec, halt, illegal;
    logic        wb_valid, flush;
    logic [31:0] in_instr, imm;
    logic [4:0]  alu_op, rd, rs1, rs2, wb_rd;

    always #5 clk = ~clk;

    instr_decode #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .src_b_imm(src_b_imm), .imm(imm), .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .sp_inc(sp_inc), .sp_dec(sp_dec), .halt(halt), .illegal(illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
    );

    typedef struct packed {
        logic [4:0]  alu_op, rd, rs1, rs2;
        logic        sbi;
        logic [31:0] imm;
        logic        we, mr, mw, spi, spd, hlt, ill;
    } exp_t;

    exp_t       expq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       busy_m[32];
    logic       ov_m, halted_m, out_we_m;
    logic [4:0] out_rd_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode straight from the opcode table.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t       e;
        logic [4:0] op;
        logic [15:0] i16;
        e      = '0;
        op     = ins[31:27];
        i16    = ins[15:0];
        e.rd   = ins[25:21];
        e.rs1  = ins[20:16];
        e.rs2  = ins[15:11];
        e.alu_op = op;
        e.sbi  = ins[26];
        e.imm  = {{16{i16[15]}}, i16};
        case (op)
            5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9: e.we = 1'b1;
            5'd7, 5'd8: begin e.we = 1'b1; e.imm = {16'h0000, i16}; end
            5'd12: begin e.we = 1'b1; e.sbi = 1'b1; end
            5'd10: begin e.alu_op = 5'd0; e.sbi = 1'b1; e.we = 1'b1; e.mr = 1'b1; end
            5'd11: begin e.alu_op = 5'd0; e.sbi = 1'b1; e.mw = 1'b1; end
            5'd17: begin e.alu_op = 5'd0; e.mw = 1'b1; e.spd = 1'b1; end
            5'd16: begin e.we = 1'b1; e.mr = 1'b1; e.spi = 1'b1; end
            5'd31: e.hlt = 1'b1;
            default: begin e.ill = 1'b1; e.sbi = 1'b0; end
        endcase
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    // Monitor: every bundle consumed by execute must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bundle: out_valid with no expected bundle at %0t", $time);
            end else begin
                e = expq.pop_front();
                chk("rd", 32'(rd), 32'(e.rd));
                chk("rs1", 32'(rs1), 32'(e.rs1));
                chk("rs2", 32'(rs2), 32'(e.rs2));
                chk("src_b_imm", 32'(src_b_imm), 32'(e.sbi));
                chk("reg_we", 32'(reg_we), 32'(e.we));
                chk("mem", {30'd0, mem_rd, mem_wr}, {30'd0, e.mr, e.mw});
                chk("sp", {30'd0, sp_inc, sp_dec}, {30'd0, e.spi, e.spd});
                chk("halt", 32'(halt), 32'(e.hlt));
                chk("illegal", 32'(illegal), 32'(e.ill));
                if (!e.ill) begin
                    chk("alu_op", 32'(alu_op), 32'(e.alu_op));
                    chk("imm", imm, e.imm);
                end
            end
        end
    end

    // One clock of stimulus, entered and left 1 time unit after a rising edge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                        input logic wv, input logic [4:0] wr, input logic fl);
        exp_t d;
        logic haz, er, acc, kill;
        in_valid = iv; in_instr = ins; out_ready = ordy; wb_valid = wv; wb_rd = wr; flush = fl;
        d   = model(ins);
        haz = busy_m[d.rs1] | (!d.sbi & busy_m[d.rs2]) | (d.we & busy_m[d.rd]);
        er  = !halted_m & !fl & !haz & (!ov_m | ordy);
        #1;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(ov_m));
        acc  = iv & er;
        kill = fl & ov_m & !ordy;
        @(posedge clk);
        if (kill) begin
            if (out_we_m) busy_m[out_rd_m] = 1'b0;
            if (expq.size() > 0) expq.delete(expq.size() - 1);
        end
        if (wv) busy_m[wr] = 1'b0;
        if (acc) begin
            if (d.we) busy_m[d.rd] = 1'b1;
            expq.push_back(d);
            ov_m = 1'b1; out_we_m = d.we; out_rd_m = d.rd;
            if (d.hlt) halted_m = 1'b1;
        end else if (ordy || fl) begin
            ov_m = 1'b0;
        end
        if (fl) halted_m = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready2", 32'(in_ready), 32'd0);
        chk("rst_bundle", {alu_op, rd, reg_we, halt, illegal, mem_rd, mem_wr, src_b_imm, 12'd0},
            32'd0);
        chk("rst_imm", imm, 32'd0);
        for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
        ov_m = 1'b0; halted_m = 1'b0; out_we_m = 1'b0; out_rd_m = '0;
        expq.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int r = 1; r < 32; r++)
            if (busy_m[r]) step(1'b0, 32'h0, 1'b1, 1'b1, 5'(r), 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    localparam logic [31:0] ADD_R3 = 32'h00611000;
    localparam logic [31:0] SUB_R4 = 32'h10830800;
    localparam logic [31:0] AND_I  = 32'h3CA08001;
    localparam logic [31:0] ADD_I  = 32'h04C08001;
    localparam logic [31:0] ADD_R8 = 32'h01011000;
    localparam logic [31:0] OR_R9  = 32'h41211000;
    localparam logic [31:0] HALT_W = 32'hF8000000;
    localparam logic [31:0] ILL_R7 = 32'hC0E00000;
    localparam logic [31:0] ADD_R0 = 32'h00010800;

    initial begin : stim
        int ops[18];
        ops = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 16, 17, 31, 24, 1, 13};
        do_reset();

        // Basic issue and RAW stall released by writeback.
        step(1'b1, ADD_R3, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("add_alu_op", 32'(alu_op), 32'd0);
        chk("add_rd", 32'(rd), 32'd3);
        chk("add_reg_we", 32'(reg_we), 32'd1);
        step(1'b1, SUB_R4, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, SUB_R4, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, SUB_R4, 1'b1, 1'b1, 5'd3, 1'b0);
        step(1'b1, SUB_R4, 1'b1, 1'b0, 5'd0, 1'b0);
        drain();

        // Immediate extension.
        step(1'b1, AND_I, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("and_imm", imm, 32'h00008001);
        chk("and_sbi", 32'(src_b_imm), 32'd1);
        step(1'b1, ADD_I, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("add_imm", imm, 32'hFFFF8001);
        drain();

        // Back-pressure: bundle held stable, next accepted as soon as out_ready returns.
        step(1'b1, ADD_R8, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, OR_R9, 1'b0, 1'b0, 5'd0, 1'b0);
            chk("hold_bundle", {19'd0, alu_op, rd, reg_we, out_valid, 1'b0}, {19'd0, 5'd0, 5'd8, 3'b110});
        end
        step(1'b1, OR_R9, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("next_rd", 32'(rd), 32'd9);
        drain();

        // HALT, then flush kills the held bundle and resumes issue.
        step(1'b1, HALT_W, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("halt_out", 32'(halt), 32'd1);
        step(1'b1, ADD_R8, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, ADD_R8, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, ADD_R8, 1'b0, 1'b0, 5'd0, 1'b1);
        chk("flush_ov", 32'(out_valid), 32'd0);
        step(1'b1, ADD_R8, 1'b1, 1'b0, 5'd0, 1'b0);
        drain();

        // Illegal opcode and rd=0 never mark a register busy.
        step(1'b1, ILL_R7, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_we", 32'(reg_we), 32'd0);
        step(1'b1, 32'h00E73800, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, ADD_R0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("r0_we", 32'(reg_we), 32'd0);
        step(1'b1, 32'h00000000, 1'b1, 1'b0, 5'd0, 1'b0);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [4:0]  op, wr, cand[$];
            logic [15:0] i16;
            logic [31:0] ins;
            logic        wv;
            op = 5'(ops[$urandom_range(0, 17)]);
            if (op == 5'd31 && $urandom_range(0, 3) != 0) op = 5'd0;
            i16 = 16'($urandom);
            if ($urandom_range(0, 1) == 0) i16[15:11] = 5'($urandom_range(0, 7));
            ins = {op, 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), i16};
            cand.delete();
            for (int r = 1; r < 8; r++) if (busy_m[r]) cand.push_back(5'(r));
            wv = 1'b0; wr = '0;
            if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
                wv = 1'b1;
                wr = cand[$urandom_range(0, cand.size() - 1)];
            end
            step($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) < 7, wv, wr,
                 $urandom_range(0, 99) < 5);
        end

        // Reset mid-operation discards the slot and the scoreboard.
        step(1'b1, ADD_R3, 1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b1, ADD_R3, 1'b0, 1'b0, 5'd0, 1'b0);
        do_reset();
        step(1'b1, SUB_R4, 1'b1, 1'b0, 5'd0, 1'b0);
        drain();
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
